// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - ALU result capture FIFO with stored status flags and valid/ready output
// Optional feature macro: ALU_RESULT_STATS_EN (adds the carry_events saturating counter port).
module alu_result_fifo #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_operation,
    input  logic [N:0]                 in_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N:0]                 out_result,
    output logic [1:0]                 out_operation,
    output logic                       out_zero,
    output logic                       out_carry,
    output logic                       out_msb,
    output logic [$clog2(DEPTH):0]     count
`ifdef ALU_RESULT_STATS_EN
    ,
    output logic [7:0]                 carry_events
`endif
);
    localparam int AW = $clog2(DEPTH);
    // Entry layout: {operation[1:0], carry, result[N:0]}; zero and msb are pure
    // functions of the stored result so they are decoded at the head.
    localparam int EW = N + 4;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push;
    logic          pop;
    logic          push_carry;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    // Ready depends only on occupancy, never on out_ready: no push-through when full.
    assign in_ready   = !rst && (count_q != FULL_CNT);
    assign out_valid  = (count_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    // Carry/borrow only has meaning for add and sub (operation[1] == 0).
    assign push_carry = !in_operation[1] && in_result[N];
    assign push_entry = {in_operation, push_carry, in_result};

    // Head fields are forced to zero while empty so stale storage never shows.
    assign head_entry    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_result    = head_entry[N:0];
    assign out_carry     = head_entry[N+1];
    assign out_operation = head_entry[N+3:N+2];
    assign out_zero      = out_valid && (head_entry[N-1:0] == '0);
    assign out_msb       = head_entry[N-1];
    assign count         = count_q;

    // Next-state for pointers and occupancy; pointers wrap modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and storage registers; reset also clears storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
        end
    end

`ifdef ALU_RESULT_STATS_EN
    logic [7:0] carry_events_q;

    assign carry_events = carry_events_q;

    // Saturating count of accepted entries whose stored carry flag is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_events_q <= '0;
        end else if (push && push_carry && (carry_events_q != 8'hFF)) begin
            carry_events_q <= carry_events_q + 8'd1;
        end
    end
`endif

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the N-bit combinational ALU. It captures each ALU result together with the 2-bit operation that produced it, and derives status flags (zero, carry/borrow, msb).
- Entries are buffered in a small FIFO and handed to the consumer over a valid/ready handshake.
- Decouples the ALU issue side from a consumer that may stall.

Parameters:
N, 4, ALU operand width; result width is N+1 (matches the ALU result port).
DEPTH, 4, number of FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  upstream presents a valid ALU result this cycle.
in_ready  output  1  block can accept an entry this cycle.
in_operation  input  2  operation applied to the ALU for this result (00 add, 01 sub, 10 and, 11 or).
in_result  input  N+1  ALU result.
out_valid  output  1  head entry is valid.
out_ready  input  1  consumer accepts the head entry.
out_result  output  N+1  head entry result.
out_operation  output  2  head entry operation.
out_zero  output  1  head entry result[N-1:0] == 0.
out_carry  output  1  head entry carry (add) or borrow (sub); 0 for and/or.
out_msb  output  1  head entry result[N-1].
count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset is synchronous, active-high, single clock (clk/rst):
  - Reset clears read pointer, write pointer and count.
  - out_valid=0, count=0, in_ready=0 during the reset cycle.
  - out_result, out_operation, out_zero, out_carry and out_msb all read 0 while empty.
  - Reset asserted mid-operation discards all stored entries; nothing pending is emitted after reset.
- Push: accepted when in_valid && in_ready at the clock edge.
  - in_ready = !rst && (count != DEPTH). It is combinational from count and does not depend on out_ready, so there is no push-through-when-full.
- Pop: occurs when out_valid && out_ready at the clock edge.
  - out_valid = (count != 0).
  - Head outputs are driven from the storage entry at the read pointer.
  - Head outputs stay stable while out_valid && !out_ready.
- Latency:
  - An entry pushed into an empty FIFO appears on out_valid the next cycle (1-cycle latency).
  - There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: both happen and count is unchanged.
  - Push and pop with count=0 cannot happen, because out_valid=0; the push alone happens.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count increments on push-only and decrements on pop-only.
- Flags are computed at push time and stored with the entry (N+4 bits per entry total):
  - zero = (in_result[N-1:0] == 0).
  - carry = in_result[N] if in_operation is 00 or 01, else 0. For sub, result[N]=1 means operand1 < operand2 (borrow).
  - msb = in_result[N-1].
- Push attempts while full (in_valid=1, in_ready=0) are ignored. Upstream must hold its data until it is accepted.
- No X propagation: storage is cleared on reset so output fields read defined values.

Optional Feature:
Macro ALU_RESULT_STATS_EN.
- Defined:
  - Adds an output port carry_events, 8 bits wide.
  - It is a saturating counter of pushed entries whose stored carry flag is 1.
  - It saturates at 255 and holds that value.
  - Reset clears it to 0.
  - It increments in the same edge as the push.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles, then release with in_valid=0 -> out_valid=0, count=0, in_ready=1 from the first cycle after reset; all out_* fields read 0.
2. Single push, N=4: push op=00, result=5'b1_0011 (9+10=19) -> next cycle out_valid=1, out_result=19, out_carry=1, out_zero=0, out_msb=0. Pop with out_ready=1 -> count returns to 0.
3. Fill to full, DEPTH=4: push 4 entries with out_ready=0 -> count=4, in_ready=0. A 5th push with in_valid=1 is ignored. Draining returns the entries in push order, checked against a scoreboard.
4. Flags: op=01 result=5'b1_1101 (3-6) -> carry=1, msb=1. op=10 result=5'b0_0000 -> zero=1, carry=0. op=11 result=5'b0_1000 -> msb=1, carry=0.
5. Simultaneous push and pop at count=2 for 10 cycles with random data -> count stays 2. Pointers wrap past DEPTH, and output order matches the scoreboard.
6. Reset mid-stream at count=3 -> the cycle after reset out_valid=0 and count=0. Previously stored entries never appear. With ALU_RESULT_STATS_EN defined: 300 add pushes with carry=1 -> carry_events=255.
